dm_ram_lsu: RTL and testbench

// - Parametrised data memory with built-in load/store unit for the pipelined CPU MEM stage.
// - Takes byte-addressed load/store requests over a valid/ready handshake and generates byte-lane masks internally.
// - Sign/zero-extends sub-word loads. Flags misaligned or out-of-range accesses.
// - Returns every request (load or store) as a single response pulse after a fixed, parametrised latency.

---
 rtl/dm_ram_lsu_if.sv | 26 ++
 rtl/dm_ram_lsu.sv | 173 +++++++++++++++++
 tb/tb_dm_ram_lsu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dm_ram_lsu_if.sv
// Request/response bus between the pipeline MEM stage and dm_ram_lsu.
interface dm_ram_lsu_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_ram_lsu.sv
// Data memory with integrated load/store unit: byte-lane stores, extended loads, fixed-latency responses.
// Optional DM_LSU_CLEAR_EN: reset sweeps the RAM to zero before accepting requests.
module dm_ram_lsu #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 3072,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    dm_ram_lsu_if.slave bus
);
    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned OFF    = $clog2(NB);
    localparam int unsigned IDX_W  = ADDR_W - OFF;
    localparam int unsigned MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic              ready_c;
    logic              accept_c;
    logic [OFF-1:0]    off_c;
    logic [IDX_W-1:0]  idx_c;
    logic              misalign_c;
    logic              illegal_c;
    logic              range_c;
    logic              err_c;
    logic              wr_c;
    logic [NB-1:0]     mask_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] word_c;
    logic [DATA_W-1:0] shift_c;
    logic [DATA_W-1:0] ext_c;
    logic              sign_c;
    rsp_t              s1_d, s1_q, rsp_q;

`ifdef DM_LSU_CLEAR_EN
    logic [MIDX_W-1:0] clr_q, clr_d;
    logic              clr_we_c;
`endif

    // State register; reset lands in CLEAR only when the sweep is built in.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef DM_LSU_CLEAR_EN
            state_q <= ST_CLEAR;
            clr_q   <= '0;
`else
            state_q <= ST_RUN;
`endif
        end else begin
            state_q <= state_d;
`ifdef DM_LSU_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
`ifdef DM_LSU_CLEAR_EN
        clr_d    = clr_q;
        clr_we_c = 1'b0;
`endif
        case (state_q)
            ST_RUN: ready_c = !rst;
`ifdef DM_LSU_CLEAR_EN
            ST_CLEAR: begin
                clr_we_c = !rst;
                clr_d    = clr_q + MIDX_W'(1);
                if (clr_q == MIDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
`endif
            default: state_d = ST_RUN;
        endcase
    end

    // Request decode: error classification, lane mask and aligned store data.
    always_comb begin
        off_c      = bus.req_addr[OFF-1:0];
        idx_c      = bus.req_addr[ADDR_W-1:OFF];
        misalign_c = |(off_c & OFF'((32'd1 << bus.req_size) - 32'd1));
        illegal_c  = (32'd8 << bus.req_size) > DATA_W;
        range_c    = 32'(idx_c) >= DEPTH;
        err_c      = misalign_c | illegal_c | range_c;
        accept_c   = bus.req_valid && ready_c;
        wr_c       = accept_c && bus.req_we && !err_c;
        for (int i = 0; i < NB; i++) begin
            mask_c[i] = (32'(i) >= 32'(off_c)) &&
                        (32'(i) < 32'(off_c) + (32'd1 << bus.req_size));
        end
        wdata_c = bus.req_wdata << {off_c, 3'b000};
    end

    // Load path: read-first word, shift the addressed lanes down, then extend.
    always_comb begin
        word_c  = range_c ? '0 : mem[MIDX_W'(idx_c)];
        shift_c = word_c >> {off_c, 3'b000};
        case (bus.req_size)
            2'd0:    sign_c = shift_c[7];
            2'd1:    sign_c = shift_c[15];
            2'd2:    sign_c = shift_c[31];
            default: sign_c = shift_c[DATA_W-1];
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            ext_c[i] = (32'(i) < (32'd8 << bus.req_size)) ? shift_c[i]
                                                           : (sign_c & ~bus.req_unsigned);
        end
        s1_d       = '0;
        s1_d.valid = accept_c;
        s1_d.err   = accept_c && err_c;
        s1_d.rdata = (accept_c && !bus.req_we && !err_c) ? ext_c : '0;
    end

    // RAM array: per-lane store writes, plus the zero sweep when enabled.
    always_ff @(posedge clk) begin
`ifdef DM_LSU_CLEAR_EN
        if (clr_we_c) begin
            mem[clr_q] <= '0;
        end
`endif
        if (wr_c) begin
            for (int i = 0; i < NB; i++) begin
                if (mask_c[i]) begin
                    mem[MIDX_W'(idx_c)][8*i +: 8] <= wdata_c[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    // Optional second response stage for the two-cycle latency build.
    generate
        if (READ_LAT >= 2) begin : g_lat2
            always_ff @(posedge clk) begin
                if (rst) begin
                    rsp_q <= '0;
                end else begin
                    rsp_q <= s1_q;
                end
            end
        end else begin : g_lat1
            assign rsp_q = s1_q;
        end
    endgenerate

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_q.valid;
    assign bus.rsp_err   = rsp_q.err;
    assign bus.rsp_rdata = rsp_q.rdata;
endmodule

// File: tb/tb_dm_ram_lsu.sv
// Directed bench for dm_ram_lsu: vector table plus back-to-back and reset/flush sequences.
module tb_dm_ram_lsu;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 3072;
    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned READ_LAT = 1;
`ifdef DM_LSU_CLEAR_EN
    localparam int unsigned CLR_CYC  = DEPTH;
    localparam logic [31:0] POST_RST = 32'h0000_0000;
`else
    localparam int unsigned CLR_CYC  = 0;
    localparam logic [31:0] POST_RST = 32'h8001_3344;
`endif

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    dm_ram_lsu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dm_ram_lsu #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [13:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.req_valid    = 1'b1;
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
    endtask

    // One request, then watch the response appear exactly READ_LAT cycles later.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        check($sformatf("vec%0d.ready", idx), 64'(bus.req_ready), 64'(1));
        for (int c = 1; c <= int'(READ_LAT); c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (c < int'(READ_LAT)) check($sformatf("vec%0d.early_valid", idx), 64'(bus.rsp_valid), 64'(0));
        end
        check($sformatf("vec%0d.valid", idx), 64'(bus.rsp_valid), 64'(1));
        check($sformatf("vec%0d.rdata", idx), 64'(bus.rsp_rdata), 64'(v.exp_rdata));
        check($sformatf("vec%0d.err", idx), 64'(bus.rsp_err), 64'(v.exp_err));
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (bus.req_ready !== 1'b1 && k < int'(DEPTH) + 16) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        vec_t vecs[$];
        vec_t b2b[4];
        logic [31:0] b2b_exp[4];
        int k;

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset.rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("reset.rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        check("reset.rsp_err", 64'(bus.rsp_err), 64'(0));
        check("reset.req_ready", 64'(bus.req_ready), 64'(0));
        rst = 1'b0;
        #1;
        wait_ready(k);
        check("reset.ready_delay", 64'(k), 64'(CLR_CYC));

        vecs.push_back(mk(1, 2'd2, 0, 14'h0010, 32'h1122_3344, 32'h0, 0));
        vecs.push_back(mk(0, 2'd2, 0, 14'h0010, 32'h0, 32'h1122_3344, 0));
        vecs.push_back(mk(1, 2'd0, 0, 14'h0013, 32'h0000_00AB, 32'h0, 0));
        vecs.push_back(mk(0, 2'd2, 0, 14'h0010, 32'h0, 32'hAB22_3344, 0));
        vecs.push_back(mk(0, 2'd0, 0, 14'h0013, 32'h0, 32'hFFFF_FFAB, 0));
        vecs.push_back(mk(0, 2'd0, 1, 14'h0013, 32'h0, 32'h0000_00AB, 0));
        vecs.push_back(mk(1, 2'd1, 0, 14'h0012, 32'h0000_8001, 32'h0, 0));
        vecs.push_back(mk(0, 2'd1, 0, 14'h0012, 32'h0, 32'hFFFF_8001, 0));
        vecs.push_back(mk(0, 2'd1, 1, 14'h0012, 32'h0, 32'h0000_8001, 0));
        vecs.push_back(mk(0, 2'd1, 0, 14'h0011, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 2'd2, 0, 14'h0010, 32'h0, 32'h8001_3344, 0));
        vecs.push_back(mk(0, 2'd1, 0, 14'h0010, 32'h0, 32'h0000_3344, 0));
        vecs.push_back(mk(0, 2'd0, 0, 14'h0012, 32'h0, 32'h0000_0001, 0));
        vecs.push_back(mk(0, 2'd0, 0, 14'h0013, 32'h0, 32'hFFFF_FF80, 0));
        vecs.push_back(mk(1, 2'd2, 0, 14'h3000, 32'hDEAD_BEEF, 32'h0, 1));
        vecs.push_back(mk(0, 2'd2, 0, 14'h3000, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 2'd2, 0, 14'h3FFC, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 2'd3, 0, 14'h0010, 32'hCAFE_F00D, 32'h0, 1));
        vecs.push_back(mk(0, 2'd3, 0, 14'h0010, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 2'd1, 0, 14'h0011, 32'h0000_FFFF, 32'h0, 1));
        vecs.push_back(mk(1, 2'd2, 0, 14'h0012, 32'h1234_5678, 32'h0, 1));
        vecs.push_back(mk(0, 2'd2, 1, 14'h0010, 32'h0, 32'h8001_3344, 0));
        vecs.push_back(mk(1, 2'd2, 0, 14'h2FFC, 32'h5A5A_0001, 32'h0, 0));
        vecs.push_back(mk(0, 2'd1, 0, 14'h2FFE, 32'h0, 32'h0000_5A5A, 0));
        vecs.push_back(mk(0, 2'd0, 1, 14'h2FFC, 32'h0, 32'h0000_0001, 0));
        vecs.push_back(mk(0, 2'd1, 0, 14'h2FFC, 32'h0, 32'h0000_0001, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Four back-to-back requests must give four consecutive in-order responses.
        b2b[0] = mk(1, 2'd2, 0, 14'h0020, 32'h0102_0304, 32'h0, 0);
        b2b[1] = mk(0, 2'd2, 0, 14'h0020, 32'h0, 32'h0, 0);
        b2b[2] = mk(1, 2'd2, 0, 14'h0020, 32'hA5A5_F00F, 32'h0, 0);
        b2b[3] = mk(0, 2'd2, 0, 14'h0020, 32'h0, 32'h0, 0);
        b2b_exp[0] = 32'h0; b2b_exp[1] = 32'h0102_0304;
        b2b_exp[2] = 32'h0; b2b_exp[3] = 32'hA5A5_F00F;
        for (int c = 0; c <= 4 + int'(READ_LAT); c++) begin
            @(negedge clk);
            if (c >= int'(READ_LAT) && c < 4 + int'(READ_LAT)) begin
                check($sformatf("b2b%0d.valid", c), 64'(bus.rsp_valid), 64'(1));
                check($sformatf("b2b%0d.rdata", c), 64'(bus.rsp_rdata), 64'(b2b_exp[c - int'(READ_LAT)]));
                check($sformatf("b2b%0d.err", c), 64'(bus.rsp_err), 64'(0));
            end else begin
                check($sformatf("b2b%0d.idle", c), 64'(bus.rsp_valid), 64'(0));
            end
            if (c < 4) begin
                drive(b2b[c]);
                check($sformatf("b2b%0d.ready", c), 64'(bus.req_ready), 64'(1));
            end else begin
                bus.req_valid = 1'b0;
            end
        end

        // Reset with a load in flight and a store presented during reset.
        @(negedge clk);
        drive(mk(0, 2'd2, 0, 14'h0010, 32'h0, 32'h0, 0));
        @(negedge clk);
        check("rst.pre_valid", 64'(bus.rsp_valid), 64'(READ_LAT == 1));
        rst = 1'b1;
        drive(mk(1, 2'd2, 0, 14'h0010, 32'h7777_7777, 32'h0, 0));
        #1;
        check("rst.ready_low", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        check("rst.flush_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst.flush_rdata", 64'(bus.rsp_rdata), 64'(0));
        check("rst.flush_err", 64'(bus.rsp_err), 64'(0));
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        wait_ready(k);
        check("rst.ready_delay", 64'(k), 64'(CLR_CYC));
        @(negedge clk);
        check("rst.no_leak", 64'(bus.rsp_valid), 64'(0));
        apply(mk(0, 2'd2, 0, 14'h0010, 32'h0, POST_RST, 0), 100);
        apply(mk(0, 2'd2, 0, 14'h0020, 32'h0, (CLR_CYC != 0) ? 32'h0 : 32'hA5A5_F00F, 0), 101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
